// File: rtl/jac_pkg.sv
// Shared definitions for the Jac1-8 CPU: widths, opcodes, status bits, instruction fields, FSM states.
package jac_pkg;

  localparam int DataWidth     = 8;
  localparam int NumOpCodeBits = 5;
  localparam int ParamBits     = 8;
  localparam int RegAddrBits   = 3;
  localparam int NumRegs       = 2 ** RegAddrBits;
  localparam int NumStatusBits = 3;
  localparam int InstrBits     = NumOpCodeBits + 2 * RegAddrBits + ParamBits;

  localparam int CARRY     = 0;
  localparam int UNDERFLOW = 1;
  localparam int ZERO      = 2;

  // {opcode[18:14], rA[13:11], rB[10:8], param[7:0]}
  localparam int OpMsb    = 18;
  localparam int OpLsb    = 14;
  localparam int RaMsb    = 13;
  localparam int RaLsb    = 11;
  localparam int RbMsb    = 10;
  localparam int RbLsb    = 8;
  localparam int ParamMsb = 7;
  localparam int ParamLsb = 0;

  typedef logic [NumOpCodeBits-1:0] opcode_t;

  localparam opcode_t OP_NOP  = 5'b0_0000;
  localparam opcode_t OP_ADD  = 5'b0_0001;
  localparam opcode_t OP_SUB  = 5'b0_0010;
  localparam opcode_t OP_AND  = 5'b0_0011;
  localparam opcode_t OP_OR   = 5'b0_0100;
  localparam opcode_t OP_NOT  = 5'b0_0101;
  localparam opcode_t OP_XOR  = 5'b0_0110;
  localparam opcode_t OP_SHL  = 5'b0_0111;
  localparam opcode_t OP_SHR  = 5'b0_1000;
  localparam opcode_t OP_VAL  = 5'b0_1001;
  localparam opcode_t OP_GOTO = 5'b1_0000;
  localparam opcode_t OP_IFZ  = 5'b1_0001;
  localparam opcode_t OP_IFNZ = 5'b1_0010;
  localparam opcode_t OP_IFEQ = 5'b1_0011;
  localparam opcode_t OP_IFST = 5'b1_0100;
  localparam opcode_t OP_IFGT = 5'b1_0101;

  typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;

  function automatic logic is_alu_op(input opcode_t op);
    return op inside {[OP_ADD:OP_SHR]};
  endfunction

  function automatic logic is_reserved(input opcode_t op);
    return op inside {[5'b0_1010:5'b0_1111], [5'b1_0110:5'b1_1111]};
  endfunction

endpackage

// File: rtl/jac_control_unit_if.sv
// Program-memory and ALU bus of the Jac1-8 sequencer; master = control unit, slave = memory/ALU side.
interface jac_control_unit_if;
  import jac_pkg::*;

  logic [ParamBits-1:0]     imem_addr;
  logic                     imem_en;
  logic [InstrBits-1:0]     imem_rdata;
  opcode_t                  alu_opcode;
  logic [DataWidth-1:0]     alu_operand1;
  logic [DataWidth-1:0]     alu_operand2;
  logic [ParamBits-1:0]     alu_param;
  logic [DataWidth-1:0]     alu_result;
  logic [NumStatusBits-1:0] alu_status;

  modport master (
    output imem_addr, imem_en, alu_opcode, alu_operand1, alu_operand2, alu_param,
    input  imem_rdata, alu_result, alu_status
  );

  modport slave (
    input  imem_addr, imem_en, alu_opcode, alu_operand1, alu_operand2, alu_param,
    output imem_rdata, alu_result, alu_status
  );

endinterface

// File: rtl/jac_regfile.sv
// 8x8 register file: two async read ports, one sync write port, async clear.
// JAC_DBG_PORT_EN adds a third async read port for debug observation.
module jac_regfile
  import jac_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   we,
  input  logic [RegAddrBits-1:0] waddr,
  input  logic [DataWidth-1:0]   wdata,
  input  logic [RegAddrBits-1:0] raddr_a,
  input  logic [RegAddrBits-1:0] raddr_b,
  output logic [DataWidth-1:0]   rdata_a,
  output logic [DataWidth-1:0]   rdata_b
`ifdef JAC_DBG_PORT_EN
  ,
  input  logic [RegAddrBits-1:0] raddr_c,
  output logic [DataWidth-1:0]   rdata_c
`endif
);

  logic [DataWidth-1:0] regs [NumRegs];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NumRegs; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];
`ifdef JAC_DBG_PORT_EN
  assign rdata_c = regs[raddr_c];
`endif

endmodule

// File: rtl/jac_control_unit.sv
// Jac1-8 instruction sequencer: fetch/decode/execute against external program memory and ALU.
// JAC_DBG_PORT_EN adds dbg_addr/dbg_data for combinational register inspection.
//
//   state  | meaning
//   FETCH  | wait for run, strobe imem at pc
//   DECODE | latch instruction word into ir
//   EXEC   | drive ALU, write back / branch at closing edge
//   HALT   | self-loop GOTO seen; idle until reset
module jac_control_unit
  import jac_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     run,
  jac_control_unit_if.master       bus,
  output logic [ParamBits-1:0]     pc,
  output logic [NumStatusBits-1:0] flags,
  output logic                     halted,
  output logic                     illegal_op
`ifdef JAC_DBG_PORT_EN
  ,
  input  logic [RegAddrBits-1:0]   dbg_addr,
  output logic [DataWidth-1:0]     dbg_data
`endif
);

  state_t                 state, state_nxt;
  logic [InstrBits-1:0]   ir;
  opcode_t                op;
  logic [RegAddrBits-1:0] ra, rb;
  logic [ParamBits-1:0]   param, pc_inc, pc_nxt;
  logic [DataWidth-1:0]   r_a, r_b, wdata;
  logic                   we, flags_we, illegal_nxt;

  assign op     = ir[OpMsb:OpLsb];
  assign ra     = ir[RaMsb:RaLsb];
  assign rb     = ir[RbMsb:RbLsb];
  assign param  = ir[ParamMsb:ParamLsb];
  assign pc_inc = pc + 1'b1;

  assign bus.imem_addr    = pc;
  assign bus.alu_operand1 = r_a;
  assign bus.alu_operand2 = r_b;
  assign bus.alu_param    = param;

  jac_regfile u_regfile (
    .clock   (clock),
    .reset   (reset),
    .we      (we),
    .waddr   (ra),
    .wdata   (wdata),
    .raddr_a (ra),
    .raddr_b (rb),
    .rdata_a (r_a),
    .rdata_b (r_b)
`ifdef JAC_DBG_PORT_EN
    ,
    .raddr_c (dbg_addr),
    .rdata_c (dbg_data)
`endif
  );

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    bus.imem_en    = 1'b0;
    bus.alu_opcode = OP_NOP;
    we             = 1'b0;
    wdata          = bus.alu_result;
    flags_we       = 1'b0;
    illegal_nxt    = 1'b0;
    case (state)
      FETCH: begin
        // gated by reset so the strobe is quiet while reset is held
        if (run && !reset) begin
          bus.imem_en = 1'b1;
          state_nxt   = DECODE;
        end
      end
      DECODE: state_nxt = EXEC;
      EXEC: begin
        state_nxt = FETCH;
        pc_nxt    = pc_inc;
        if (is_alu_op(op)) begin
          bus.alu_opcode = op;
          we             = 1'b1;
          flags_we       = 1'b1;
        end else begin
          case (op)
            OP_VAL: begin
              we    = 1'b1;
              wdata = param;
            end
            OP_GOTO: begin
              pc_nxt = param;
              if (param == pc) state_nxt = HALT;
            end
            OP_IFZ:  if (flags[ZERO])  pc_nxt = param;
            OP_IFNZ: if (!flags[ZERO]) pc_nxt = param;
            // compares reuse SUB; the status is consumed here and not stored in flags
            OP_IFEQ: begin
              bus.alu_opcode = OP_SUB;
              if (bus.alu_status[ZERO]) pc_nxt = param;
            end
            OP_IFST: begin
              bus.alu_opcode = OP_SUB;
              if (bus.alu_status[UNDERFLOW]) pc_nxt = param;
            end
            OP_IFGT: begin
              bus.alu_opcode = OP_SUB;
              if (!bus.alu_status[ZERO] && !bus.alu_status[UNDERFLOW]) pc_nxt = param;
            end
            default: illegal_nxt = is_reserved(op);
          endcase
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= '0;
      ir         <= '0;
      flags      <= '0;
      halted     <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      halted     <= (state_nxt == HALT);
      illegal_op <= illegal_nxt;
      if (state == DECODE) ir <= bus.imem_rdata;
      if (flags_we) flags <= bus.alu_status;
    end
  end

endmodule

// File: tb/tb_jac_control_unit.sv
// Self-checking bench for jac_control_unit: directed programs plus random programs vs an ISA-level model.
module tb_jac_control_unit;
  import jac_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       run;
  logic [7:0] pc;
  logic [2:0] flags;
  logic       halted;
  logic       illegal_op;
`ifdef JAC_DBG_PORT_EN
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;
`endif

  jac_control_unit_if bus ();

  jac_control_unit dut (
    .clock      (clock),
    .reset      (reset),
    .run        (run),
    .bus        (bus),
    .pc         (pc),
    .flags      (flags),
    .halted     (halted),
    .illegal_op (illegal_op)
`ifdef JAC_DBG_PORT_EN
    ,
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
`endif
  );

  always #5 clock = ~clock;

  logic [18:0] mem [256];
  always @(posedge clock) if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];

  // external ALU behaviour: returns {zero, underflow, carry, result}
  function automatic logic [10:0] alu_fn(input opcode_t op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] w;
    logic c, u;
    w = 9'd0; c = 1'b0; u = 1'b0;
    case (op)
      OP_ADD: begin w = {1'b0, a} + {1'b0, b}; c = w[8]; end
      OP_SUB: begin w = {1'b0, a} - {1'b0, b}; u = (a < b); end
      OP_AND: w[7:0] = a & b;
      OP_OR:  w[7:0] = a | b;
      OP_NOT: w[7:0] = ~b;
      OP_XOR: w[7:0] = a ^ b;
      OP_SHL: begin w[7:0] = a << 1; c = a[7]; end
      OP_SHR: begin w[7:0] = a >> 1; c = a[0]; end
      default: ;
    endcase
    return {(w[7:0] == 8'd0), u, c, w[7:0]};
  endfunction

  always_comb {bus.alu_status, bus.alu_result} = alu_fn(bus.alu_opcode, bus.alu_operand1, bus.alu_operand2);

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ISA-level reference state
  logic [7:0] m_pc, m_r [8];
  logic [2:0] m_flags;
  logic       m_halted, ill_now, retired;
  int         ph;  // 0 fetch slot, 1 decode, 2 execute, 3 halted

  function automatic logic [18:0] ins(input opcode_t op, input int a, input int b, input int p);
    return {op, a[2:0], b[2:0], p[7:0]};
  endfunction

  task automatic model_exec();
    logic [18:0] i;
    opcode_t op;
    logic [2:0] a, b;
    logic [7:0] x, y, p, nxt;
    logic [10:0] sr;
    i = mem[m_pc]; op = i[18:14]; a = i[13:11]; b = i[10:8]; p = i[7:0];
    x = m_r[a]; y = m_r[b]; nxt = m_pc + 8'd1;
    if (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_XOR, OP_SHL, OP_SHR}) begin
      sr = alu_fn(op, x, y);
      m_r[a] = sr[7:0];
      m_flags = sr[10:8];
    end else begin
      case (op)
        OP_VAL:  m_r[a] = p;
        OP_NOP:  ;
        OP_GOTO: begin nxt = p; if (p == m_pc) m_halted = 1'b1; end
        OP_IFZ:  if (m_flags[2])  nxt = p;
        OP_IFNZ: if (!m_flags[2]) nxt = p;
        OP_IFEQ: if (x == y) nxt = p;
        OP_IFST: if (x < y)  nxt = p;
        OP_IFGT: if (x > y)  nxt = p;
        default: ill_now = 1'b1;
      endcase
    end
    m_pc = nxt;
  endtask

  task automatic step(input logic r);
    logic [18:0] i;
    opcode_t op, exp_alu;
    run = r;
`ifdef JAC_DBG_PORT_EN
    dbg_addr = 3'($urandom_range(0, 7));
`endif
    @(negedge clock);
    i = mem[m_pc]; op = i[18:14];
    check("imem_en", 32'(bus.imem_en), 32'(ph == 0 && r));
    if (ph == 0 && r) check("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
    exp_alu = OP_NOP;
    if (ph == 2) begin
      if (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_XOR, OP_SHL, OP_SHR}) exp_alu = op;
      else if (op inside {OP_IFEQ, OP_IFST, OP_IFGT}) exp_alu = OP_SUB;
    end
    check("alu_opcode", 32'(bus.alu_opcode), 32'(exp_alu));
    if (exp_alu != OP_NOP) begin
      check("alu_operand1", 32'(bus.alu_operand1), 32'(m_r[i[13:11]]));
      check("alu_operand2", 32'(bus.alu_operand2), 32'(m_r[i[10:8]]));
    end
    check("pc", 32'(pc), 32'(m_pc));
    check("flags", 32'(flags), 32'(m_flags));
    check("halted", 32'(halted), 32'(m_halted));
    check("illegal_op", 32'(illegal_op), 32'(ill_now));
`ifdef JAC_DBG_PORT_EN
    check("dbg_data", 32'(dbg_data), 32'(m_r[dbg_addr]));
`endif
    if (retired) begin
      for (int k = 0; k < 8; k++) check($sformatf("R%0d", k), 32'(dut.u_regfile.regs[k]), 32'(m_r[k]));
      retired = 1'b0;
    end
    @(posedge clock);
    ill_now = 1'b0;
    case (ph)
      0: if (r) ph = 1;
      1: ph = 2;
      2: begin model_exec(); retired = 1'b1; ph = m_halted ? 3 : 0; end
      default: ;
    endcase
    #1;
  endtask

  task automatic steps(input int n);
    for (int s = 0; s < n; s++) step(1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_illegal_op", 32'(illegal_op), 32'd0);
    check("rst_imem_en", 32'(bus.imem_en), 32'd0);
    check("rst_alu_opcode", 32'(bus.alu_opcode), 32'(OP_NOP));
    for (int k = 0; k < 8; k++) check($sformatf("rst_R%0d", k), 32'(dut.u_regfile.regs[k]), 32'd0);
    m_pc = 8'd0; m_flags = 3'd0; m_halted = 1'b0; ill_now = 1'b0; retired = 1'b0; ph = 0;
    for (int k = 0; k < 8; k++) m_r[k] = 8'd0;
    run = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_mem();
    for (int k = 0; k < 256; k++) mem[k] = 19'd0;
  endtask

  initial begin
    reset = 1'b1;
    run   = 1'b0;
`ifdef JAC_DBG_PORT_EN
    dbg_addr = 3'd0;
`endif
    clear_mem();
    #12;

    // basic add; then reset asserted while the second VAL is in execute
    mem[0] = ins(OP_VAL, 1, 0, 5);
    mem[1] = ins(OP_VAL, 2, 0, 3);
    mem[2] = ins(OP_ADD, 1, 2, 0);
    do_reset();
    steps(9);
    check("addA_R1", 32'(dut.u_regfile.regs[1]), 32'd8);
    check("addA_pc", 32'(pc), 32'd3);
    check("addA_flags", 32'(flags), 32'd0);
    do_reset();
    steps(5);
    run = 1'b1;
    do_reset();
    step(1'b1);

    // carry out of ADD, then IFZ not taken
    clear_mem();
    mem[0] = ins(OP_VAL, 1, 0, 200);
    mem[1] = ins(OP_VAL, 2, 0, 100);
    mem[2] = ins(OP_ADD, 1, 2, 0);
    mem[3] = ins(OP_IFZ, 0, 0, 8'h40);
    do_reset();
    steps(9);
    check("addB_R1", 32'(dut.u_regfile.regs[1]), 32'd44);
    check("addB_flags", 32'(flags), 32'b001);
    steps(3);
    check("ifz_pc", 32'(pc), 32'd4);

    // IFST taken, IFGT not taken
    clear_mem();
    mem[0]    = ins(OP_VAL, 1, 0, 3);
    mem[1]    = ins(OP_VAL, 2, 0, 7);
    mem[2]    = ins(OP_IFST, 1, 2, 8'h20);
    mem[8'h20] = ins(OP_IFGT, 1, 2, 8'h30);
    do_reset();
    steps(9);
    check("ifst_pc", 32'(pc), 32'h20);
    check("ifst_flags", 32'(flags), 32'd0);
    steps(3);
    check("ifgt_pc", 32'(pc), 32'h21);

    // reserved opcode
    clear_mem();
    mem[0] = ins(5'b1_1000, 3, 4, 8'h77);
    do_reset();
    steps(3);
    check("illegal_pulse", 32'(illegal_op), 32'd1);
    check("illegal_pc", 32'(pc), 32'd1);
    steps(1);
    check("illegal_end", 32'(illegal_op), 32'd0);

    // pc wrap
    clear_mem();
    mem[0]     = ins(OP_GOTO, 0, 0, 8'hFE);
    mem[8'hFE] = ins(OP_GOTO, 0, 0, 8'hFF);
    do_reset();
    steps(6);
    check("goto_ff_pc", 32'(pc), 32'hFF);
    steps(3);
    check("wrap_pc", 32'(pc), 32'h00);

    // self-loop halts; run is then ignored
    clear_mem();
    mem[0] = ins(OP_GOTO, 0, 0, 5);
    mem[5] = ins(OP_GOTO, 0, 0, 5);
    do_reset();
    steps(6);
    check("halt_flag", 32'(halted), 32'd1);
    for (int s = 0; s < 10; s++) step(1'($urandom_range(0, 1)));
    check("halt_pc", 32'(pc), 32'd5);

    // run dropped while ADD executes: ADD retires, then fetch stalls
    clear_mem();
    mem[0] = ins(OP_VAL, 1, 0, 5);
    mem[1] = ins(OP_VAL, 2, 0, 3);
    mem[2] = ins(OP_ADD, 1, 2, 0);
    do_reset();
    steps(8);
    step(1'b0);
    check("stall_R1", 32'(dut.u_regfile.regs[1]), 32'd8);
    check("stall_pc", 32'(pc), 32'd3);
    for (int s = 0; s < 4; s++) step(1'b0);
    steps(3);

    // random programs with random run
    for (int rnd = 0; rnd < 4; rnd++) begin
      for (int k = 0; k < 256; k++) mem[k] = 19'($urandom);
      do_reset();
      for (int s = 0; s < 300; s++) step(1'($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
